diffeq_controller: RTL and testbench

Control FSM that drives the diffeq datapath directly upstream of it. It sequences serial 4-bit operand loading in the order x, dx, a, u, then steps the datapath through COMPUTE_1..COMPUTE_4 using the datapath's compute_done and continue_while. It counts loop iterations and aborts on an iteration limit or a stalled compute stage. Its state output is the datapath's state input.

---
 rtl/diffeq_pkg.sv | 26 ++
 rtl/diffeq_controller.sv | 142 ++++++++++++++
 tb/tb_diffeq_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/diffeq_pkg.sv
// rtl/diffeq_pkg.sv - shared state and operand encodings for the diffeq controller and datapath
package diffeq_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE      = 3'b000;
    localparam state_t S_READ      = 3'b001;
    localparam state_t S_COMPUTE_1 = 3'b010;
    localparam state_t S_COMPUTE_2 = 3'b011;
    localparam state_t S_COMPUTE_3 = 3'b100;
    localparam state_t S_COMPUTE_4 = 3'b101;
    localparam state_t S_DONE      = 3'b110;

    localparam logic [1:0] OP_X  = 2'd0;
    localparam logic [1:0] OP_DX = 2'd1;
    localparam logic [1:0] OP_A  = 2'd2;
    localparam logic [1:0] OP_U  = 2'd3;

    function automatic logic is_compute(input state_t s);
        return (s == S_COMPUTE_1) || (s == S_COMPUTE_2) ||
               (s == S_COMPUTE_3) || (s == S_COMPUTE_4);
    endfunction

endpackage

// File: rtl/diffeq_controller.sv
// rtl/diffeq_controller.sv - operand load sequencer and compute-loop FSM for the diffeq datapath
module diffeq_controller
    import diffeq_pkg::*;
#(
    parameter int ITER_W     = 8,
    parameter int MAX_ITER   = 200,
    parameter int WAIT_W     = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load_x,
    output logic              load_dx,
    output logic              load_a,
    output logic              load_u,
    output logic [2:0]        state,
    input  logic              compute_done,
    input  logic              continue_while,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              err_timeout,
    output logic              err_iter
);

    state_t              state_next;
    logic [1:0]          read_idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ITER_W-1:0]   iter_next;
    logic                accept;
    logic                qual_done;
    logic                wait_expired;
    logic                at_limit;

    // The datapath's compute_done is registered, so on the first cycle of a
    // stage it still reflects the previous stage and must be ignored.
    assign accept       = (state == S_READ) && in_valid;
    assign qual_done    = compute_done && (wait_cnt != '0);
    assign wait_expired = (wait_cnt == WAIT_W'(WAIT_LIMIT));
    assign iter_next    = iter_count + ITER_W'(1);
    assign at_limit     = (iter_next == ITER_W'(MAX_ITER));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a qualifying done takes priority over a timeout
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_READ;
            end
            S_READ: begin
                if (accept && (read_idx == OP_U)) state_next = S_COMPUTE_1;
            end
            S_COMPUTE_1: begin
                if (qual_done)         state_next = S_COMPUTE_2;
                else if (wait_expired) state_next = S_DONE;
            end
            S_COMPUTE_2: begin
                if (qual_done)         state_next = S_COMPUTE_3;
                else if (wait_expired) state_next = S_DONE;
            end
            S_COMPUTE_3: begin
                if (qual_done)         state_next = S_COMPUTE_4;
                else if (wait_expired) state_next = S_DONE;
            end
            S_COMPUTE_4: begin
                if (qual_done) begin
                    if (!continue_while || at_limit) state_next = S_DONE;
                    else                             state_next = S_COMPUTE_1;
                end else if (wait_expired) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; load strobes follow the handshake directly
    always_comb begin
        in_ready = (state == S_READ);
        load_x   = accept && (read_idx == OP_X);
        load_dx  = accept && (read_idx == OP_DX);
        load_a   = accept && (read_idx == OP_A);
        load_u   = accept && (read_idx == OP_U);
        busy     = (state != S_IDLE) && (state != S_DONE) && (state != 3'b111);
        done     = (state == S_DONE);
    end

    // Read index, stage wait counter, iteration counter and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_idx    <= '0;
            wait_cnt    <= '0;
            iter_count  <= '0;
            err_timeout <= 1'b0;
            err_iter    <= 1'b0;
        end else begin
            if ((state == S_IDLE) && start) begin
                iter_count  <= '0;
                err_timeout <= 1'b0;
                err_iter    <= 1'b0;
            end

            // Two-bit index wraps back to X after the U nibble
            if (accept) begin
                read_idx <= read_idx + 2'd1;
            end

            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (is_compute(state) && !wait_expired) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if ((state == S_COMPUTE_4) && qual_done) begin
                iter_count <= iter_next;
                if (continue_while && at_limit) err_iter <= 1'b1;
            end

            if (is_compute(state) && !qual_done && wait_expired) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_diffeq_controller.sv
// tb/tb_diffeq_controller.sv - self-checking bench for diffeq_controller
module tb_diffeq_controller;

    localparam int ITER_W = 8;
    localparam int MAXI   = 3;
    localparam int WLIM   = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              compute_done = 1'b0;
    logic              continue_while = 1'b0;
    logic              in_ready, load_x, load_dx, load_a, load_u;
    logic [2:0]        state;
    logic              busy, done, err_timeout, err_iter;
    logic [ITER_W-1:0] iter_count;

    int n_total = 0;
    int n_pass  = 0;

    // reference model: phase 0 idle, 1 loading, 2..5 compute stages, 6 finished
    int m_stage = 0;
    int m_nib   = 0;
    int m_cyc   = 0;
    int m_iters = 0;
    bit m_eto   = 0;
    bit m_eit   = 0;

    diffeq_controller #(
        .ITER_W(ITER_W), .MAX_ITER(MAXI), .WAIT_W(4), .WAIT_LIMIT(WLIM)
    ) dut (
        .clk(clk), .reset(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .load_x(load_x), .load_dx(load_dx),
        .load_a(load_a), .load_u(load_u), .state(state),
        .compute_done(compute_done), .continue_while(continue_while),
        .busy(busy), .done(done), .iter_count(iter_count),
        .err_timeout(err_timeout), .err_iter(err_iter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        logic [3:0]  ld;
        logic [19:0] expv, actv;
        bit          qd;
        if (rst) begin
            m_stage = 0; m_nib = 0; m_cyc = 0; m_iters = 0; m_eto = 0; m_eit = 0;
        end
        ld = (m_stage == 1 && in_valid) ? (4'b1000 >> m_nib) : 4'b0000;
        expv = {3'(m_stage), (m_stage == 1), ld, (m_stage >= 1 && m_stage <= 5),
                (m_stage == 6), 8'(m_iters), m_eto, m_eit};
        actv = {state, in_ready, load_x, load_dx, load_a, load_u, busy, done,
                iter_count, err_timeout, err_iter};
        chk("cycle_outputs", 32'(actv), 32'(expv));
        if (!rst) begin
            case (m_stage)
                0: if (start) begin
                    m_stage = 1; m_nib = 0; m_iters = 0; m_eto = 0; m_eit = 0;
                end
                1: if (in_valid) begin
                    m_nib++;
                    if (m_nib == 4) begin m_stage = 2; m_cyc = 0; m_nib = 0; end
                end
                6: m_stage = 0;
                default: begin
                    qd = compute_done && (m_cyc > 0);
                    if (qd) begin
                        if (m_stage < 5) begin
                            m_stage++; m_cyc = 0;
                        end else begin
                            m_iters++;
                            if (!continue_while) m_stage = 6;
                            else if (m_iters == MAXI) begin m_stage = 6; m_eit = 1; end
                            else begin m_stage = 2; m_cyc = 0; end
                        end
                    end else if (m_cyc >= WLIM) begin
                        m_stage = 6; m_eto = 1;
                    end else begin
                        m_cyc++;
                    end
                end
            endcase
        end
    end

    // Pulse start, then feed nibbles according to pat; optionally pin strobes literally
    task automatic start_load(input logic [5:0] pat, input int len, input bit pin);
        logic [3:0] exp_ld [6];
        int k = 0;
        exp_ld[0] = 4'b1000; exp_ld[1] = 4'b0000; exp_ld[2] = 4'b0100;
        exp_ld[3] = 4'b0010; exp_ld[4] = 4'b0000; exp_ld[5] = 4'b0001;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < len; i++) begin
            in_valid = pat[len-1-i];
            @(negedge clk);
            if (pin) chk($sformatf("load_strobe_%0d", i),
                         32'({load_x, load_dx, load_a, load_u}), 32'(exp_ld[k]));
            k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // cdmode 0: done one cycle after entry; 1: done held high; 2: like 0 but never in stage 3
    task automatic run_to_done(input int cdmode, input int cwdrop,
                               output int ncomp, output int n3, output int first_state);
        bit seen = 0;
        ncomp = 0; n3 = 0; first_state = -1;
        for (int c = 0; c < 400; c++) begin
            case (cdmode)
                0: compute_done = (m_stage >= 2 && m_stage <= 5 && m_cyc == 1);
                1: compute_done = 1'b1;
                default: compute_done = (m_stage >= 2 && m_stage <= 5 && m_stage != 4 && m_cyc == 1);
            endcase
            continue_while = (cwdrop == 0) ? 1'b1 : ((m_iters + 1) < cwdrop);
            @(negedge clk);
            if (c == 0) first_state = int'(state);
            if (done) begin seen = 1; break; end
            if (state >= 3'd2 && state <= 3'd5) ncomp++;
            if (state == 3'd4) n3++;
            @(posedge clk); #1;
        end
        if (!seen) chk("done_within_budget", 32'd0, 32'd1);
        @(posedge clk); #1 compute_done = 1'b0; continue_while = 1'b0;
        @(negedge clk);
        chk("idle_after_done", 32'(state), 32'd0);
    endtask

    initial begin
        int nc, n3, fs;
        @(negedge clk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_flags", 32'({in_ready, busy, done, err_timeout, err_iter, iter_count}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // idle ignores in_valid
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("idle_no_strobe", 32'({load_x, load_dx, load_a, load_u, state}), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // load order with gaps, then a single iteration
        start_load(6'b101101, 6, 1'b1);
        run_to_done(0, 1, nc, n3, fs);
        chk("c1_after_u", 32'(fs), 32'd2);
        chk("single_compute_cycles", 32'(nc), 32'd8);
        chk("single_iter_count", 32'(iter_count), 32'd1);
        chk("single_errs", 32'({err_timeout, err_iter}), 32'd0);

        // stale done held high still takes two cycles per stage
        start_load(6'b001111, 4, 1'b0);
        run_to_done(1, 1, nc, n3, fs);
        chk("stale_compute_cycles", 32'(nc), 32'd8);
        chk("stale_iter_count", 32'(iter_count), 32'd1);

        // iteration limit
        start_load(6'b001111, 4, 1'b0);
        run_to_done(0, 0, nc, n3, fs);
        chk("limit_compute_cycles", 32'(nc), 32'd24);
        chk("limit_iter_count", 32'(iter_count), 32'd3);
        chk("limit_err_iter", 32'(err_iter), 32'd1);

        // loop condition drops on iteration 2
        start_load(6'b001111, 4, 1'b0);
        run_to_done(0, 2, nc, n3, fs);
        chk("drop_compute_cycles", 32'(nc), 32'd16);
        chk("drop_iter_count", 32'(iter_count), 32'd2);
        chk("drop_err_iter", 32'(err_iter), 32'd0);

        // stage 3 timeout
        start_load(6'b001111, 4, 1'b0);
        run_to_done(2, 1, nc, n3, fs);
        chk("timeout_stage3_cycles", 32'(n3), 32'd16);
        chk("timeout_err", 32'({err_timeout, err_iter}), 32'b10);
        chk("timeout_iter_count", 32'(iter_count), 32'd0);

        // flag holds in IDLE, clears on accepted start
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        chk("err_hold_idle", 32'(err_timeout), 32'd1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("err_cleared_on_start", 32'({state, err_timeout}), 32'b0010);

        // reset in the middle of COMPUTE_2
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 in_valid = 1'b1;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        for (int c = 0; c < 20 && m_stage != 3; c++) begin
            compute_done = (m_cyc == 1);
            @(posedge clk); #1;
        end
        chk("reached_compute_2", 32'(m_stage), 32'd3);
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_outputs", 32'({load_x, load_dx, load_a, load_u, in_ready, busy, done}), 32'd0);
        @(posedge clk); #1 rst = 1'b0; compute_done = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 32'({state, load_x, load_dx, load_a, load_u}), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
